// File: rtl/intc_cpu_responder_pkg.sv
// Shared interrupt-controller definitions: responder state encoding, IACK width
// default and the controller's ISR vector register map.
package intc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ACK      = 3'd1,
        ST_REDIRECT = 3'd2,
        ST_SERVICE  = 3'd3,
        ST_RETURN   = 3'd4
    } intc_state_e;

    localparam int unsigned IACK_CYCLES_DEF = 1;

    localparam logic [31:0] INTC_ISR_STRIDE = 32'h0000_0004;
    localparam logic [31:0] INTC_ISR0_ADDR  = 32'h0000_2000;
    localparam logic [31:0] INTC_ISR1_ADDR  = 32'h0000_2004;
    localparam logic [31:0] INTC_ISR2_ADDR  = 32'h0000_2008;
    localparam logic [31:0] INTC_ISR3_ADDR  = 32'h0000_200C;

    function automatic logic [31:0] intc_isr_reg_addr(input logic [1:0] idx);
        return INTC_ISR0_ADDR + ({30'd0, idx} * INTC_ISR_STRIDE);
    endfunction

endpackage

// File: rtl/intc_cpu_responder_iack_pulse.sv
// Loadable down-counter: holds pulse high for IACK_CYCLES cycles after load and
// flags done during the last of those cycles.
module intc_iack_pulse
    import intc_pkg::*;
#(
    parameter int unsigned IACK_CYCLES = IACK_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic pulse,
    output logic done
);

    localparam logic [3:0] LOAD_VAL = 4'(IACK_CYCLES - 1);

    logic [3:0] cnt_r;

    // Pulse generation: load arms the counter, pulse drops once it has hit zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= 4'd0;
            pulse <= 1'b0;
        end else if (load) begin
            cnt_r <= LOAD_VAL;
            pulse <= 1'b1;
        end else if (pulse) begin
            if (cnt_r == 4'd0) begin
                pulse <= 1'b0;
            end else begin
                cnt_r <= cnt_r - 4'd1;
            end
        end
    end

    assign done = pulse && (cnt_r == 4'd0);

endmodule

// File: rtl/intc_cpu_responder.sv
// CPU-side interrupt responder: accept, IACK, ISR redirect, ERET return.
// Optional accepted-interrupt counter is built when INTC_CPU_RESPONDER_STATS_EN is defined.
module intc_cpu_responder
    import intc_pkg::*;
#(
    parameter int unsigned IACK_CYCLES = IACK_CYCLES_DEF,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              irq,
    input  logic [ADDR_W-1:0] isr_addr,
    input  logic              gie,
    input  logic              inst_boundary,
    input  logic [ADDR_W-1:0] pc_next,
    input  logic              eret,
    output logic              iack,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] epc,
    output logic              in_service,
    output logic [CNT_W-1:0]  irq_count
);

    intc_state_e       state_r;
    logic [ADDR_W-1:0] vec_r;
    logic              accept_s;
    logic              iack_done_s;

    assign accept_s = (state_r == ST_IDLE) && irq && gie && inst_boundary;

    intc_iack_pulse #(
        .IACK_CYCLES (IACK_CYCLES)
    ) u_iack_pulse (
        .clk   (clk),
        .rst   (rst),
        .load  (accept_s),
        .pulse (iack),
        .done  (iack_done_s)
    );

    // Handshake sequencer; redirect_valid defaults low so every strobe lasts one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            vec_r          <= {ADDR_W{1'b0}};
            redirect_valid <= 1'b0;
            redirect_pc    <= {ADDR_W{1'b0}};
            epc            <= {ADDR_W{1'b0}};
            in_service     <= 1'b0;
        end else begin
            redirect_valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        epc        <= pc_next;
                        vec_r      <= isr_addr;
                        in_service <= 1'b1;
                        state_r    <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (iack_done_s) begin
                        redirect_valid <= 1'b1;
                        redirect_pc    <= vec_r;
                        state_r        <= ST_REDIRECT;
                    end
                end
                ST_REDIRECT: begin
                    state_r <= ST_SERVICE;
                end
                ST_SERVICE: begin
                    // A pending irq here stays with the controller; eret always wins.
                    if (eret) begin
                        redirect_valid <= 1'b1;
                        redirect_pc    <= epc;
                        state_r        <= ST_RETURN;
                    end
                end
                ST_RETURN: begin
                    in_service <= 1'b0;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    in_service <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef INTC_CPU_RESPONDER_STATS_EN
    logic [CNT_W-1:0] cnt_r;

    // Saturating count of accepted interrupts.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign irq_count = cnt_r;
`else
    assign irq_count = {CNT_W{1'b0}};
`endif

endmodule
